// File: rtl/pipelined_cpu_if.sv
// Memory bus of the pipelined CPU: instruction fetch port, load port and store port.
interface pipelined_cpu_if;
    logic [31:0] mem_read0_addr;
    logic [31:0] mem_read0_data;
    logic [31:0] mem_read1_addr;
    logic [31:0] mem_read1_data;
    logic        mem_write_en;
    logic [31:0] mem_write_addr;
    logic [31:0] mem_write_data;

    modport master (
        output mem_read0_addr,
        input  mem_read0_data,
        output mem_read1_addr,
        input  mem_read1_data,
        output mem_write_en,
        output mem_write_addr,
        output mem_write_data
    );

    modport slave (
        input  mem_read0_addr,
        output mem_read0_data,
        input  mem_read1_addr,
        output mem_read1_data,
        input  mem_write_en,
        input  mem_write_addr,
        input  mem_write_data
    );
endinterface

// File: rtl/pipelined_cpu.sv
// Five-stage in-order 32-bit CPU (F/D/E/M/W) with full forwarding, load-use stall,
// branch/JALR resolution in E and a HALT that freezes fetch until reset.
module pipelined_cpu (
    input  logic            clk,
    input  logic            reset,
    pipelined_cpu_if.master mem,
    output logic [31:0]     ret_val,
    output logic [3:0]      flags,
    output logic [31:0]     cpu_pc
);
    localparam logic [4:0] OP_ALU  = 5'd0;
    localparam logic [4:0] OP_ALUI = 5'd1;
    localparam logic [4:0] OP_LUI  = 5'd2;
    localparam logic [4:0] OP_LD   = 5'd3;
    localparam logic [4:0] OP_ST   = 5'd4;
    localparam logic [4:0] OP_BR   = 5'd5;
    localparam logic [4:0] OP_JALR = 5'd6;
    localparam logic [4:0] OP_HALT = 5'd31;
    localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

    // Returns {C, Z, S, O, result}.
    function automatic logic [35:0] alu(input logic [4:0] func, input logic [31:0] a, input logic [31:0] b);
        logic [32:0] sum;
        logic [31:0] r;
        logic        c;
        logic        o;
        sum = 33'd0;
        r   = 32'd0;
        c   = 1'b0;
        o   = 1'b0;
        case (func)
            5'd0: begin
                sum = {1'b0, a} + {1'b0, b};
                r = sum[31:0];
                c = sum[32];
                o = (a[31] == b[31]) && (r[31] != a[31]);
            end
            5'd1: begin
                sum = {1'b0, a} - {1'b0, b};
                r = sum[31:0];
                c = sum[32];
                o = (a[31] != b[31]) && (r[31] != a[31]);
            end
            5'd2:    r = a & b;
            5'd3:    r = a | b;
            5'd4:    r = a ^ b;
            5'd5:    r = a << b[4:0];
            5'd6:    r = a >> b[4:0];
            5'd7:    r = $signed(a) >>> b[4:0];
            default: r = 32'd0;
        endcase
        return {c, (r == 32'd0), r[31], o, r};
    endfunction

    function automatic logic [31:0] fwd(input logic [4:0] idx, input logic [31:0] base,
                                        input logic m_en, input logic [4:0] m_rd, input logic [31:0] m_val,
                                        input logic w_en, input logic [4:0] w_rd, input logic [31:0] w_val);
        logic [31:0] v;
        if (idx == 5'd0)                 v = 32'd0;
        else if (m_en && (m_rd == idx))  v = m_val;
        else if (w_en && (w_rd == idx))  v = w_val;
        else                             v = base;
        return v;
    endfunction

    logic [31:0] rf [32];
    logic [31:0] pc_r;
    logic        halted_r;
    logic        fd_valid_r;
    logic [31:0] fd_ins_r, fd_pc_r;
    logic        de_valid_r;
    logic [31:0] de_ins_r, de_pc_r, de_ra_val_r, de_rb_val_r, de_rc_val_r;
    logic        em_wen_r, em_load_r, em_we_r;
    logic [4:0]  em_rd_r;
    logic [31:0] em_result_r, em_addr_r, em_wdata_r;
    logic        mw_wen_r;
    logic [4:0]  mw_rd_r;
    logic [31:0] mw_data_r;
    logic [3:0]  flags_r;

    logic [4:0]  d_op, d_ra, d_rb, d_rc;
    logic [31:0] d_ra_val, d_rb_val, d_rc_val;
    logic        load_use, fetch_halt;
    logic [4:0]  e_op, e_rd, e_rb, e_rc, e_func;
    logic [31:0] e_a, e_c, e_sd, e_imm12, e_imm17, e_imm22, e_result, e_addr, e_target;
    logic [35:0] e_aluv;
    logic        e_wen, e_load, e_store, e_flag_we, e_taken, e_cond;

    // Decode: register read with W-stage write-through and load-use detection.
    always_comb begin
        d_op = fd_ins_r[31:27];
        d_ra = fd_ins_r[26:22];
        d_rb = fd_ins_r[21:17];
        d_rc = fd_ins_r[4:0];
        d_ra_val = fwd(d_ra, rf[d_ra], 1'b0, 5'd0, 32'd0, mw_wen_r, mw_rd_r, mw_data_r);
        d_rb_val = fwd(d_rb, rf[d_rb], 1'b0, 5'd0, 32'd0, mw_wen_r, mw_rd_r, mw_data_r);
        d_rc_val = fwd(d_rc, rf[d_rc], 1'b0, 5'd0, 32'd0, mw_wen_r, mw_rd_r, mw_data_r);
        if (fd_valid_r && de_valid_r && (de_ins_r[31:27] == OP_LD) && (de_ins_r[26:22] != 5'd0)) begin
            load_use = ((d_op <= OP_ST || d_op == OP_JALR) && (d_rb == de_ins_r[26:22]))
                     || ((d_op == OP_ALU) && (d_rc == de_ins_r[26:22]))
                     || ((d_op == OP_ST) && (d_ra == de_ins_r[26:22]));
        end else begin
            load_use = 1'b0;
        end
        fetch_halt = (mem.mem_read0_data[31:27] == OP_HALT);
    end

    // Execute: forwarded operands, ALU, address generation and branch resolution.
    always_comb begin
        e_op    = de_ins_r[31:27];
        e_rd    = de_ins_r[26:22];
        e_rb    = de_ins_r[21:17];
        e_func  = de_ins_r[16:12];
        e_rc    = de_ins_r[4:0];
        e_imm12 = {{20{de_ins_r[11]}}, de_ins_r[11:0]};
        e_imm17 = {{15{de_ins_r[16]}}, de_ins_r[16:0]};
        e_imm22 = {{10{de_ins_r[21]}}, de_ins_r[21:0]};
        e_a  = fwd(e_rb, de_rb_val_r, em_wen_r, em_rd_r, em_result_r, mw_wen_r, mw_rd_r, mw_data_r);
        e_c  = fwd(e_rc, de_rc_val_r, em_wen_r, em_rd_r, em_result_r, mw_wen_r, mw_rd_r, mw_data_r);
        e_sd = fwd(e_rd, de_ra_val_r, em_wen_r, em_rd_r, em_result_r, mw_wen_r, mw_rd_r, mw_data_r);
        e_aluv = alu(e_func, e_a, (e_op == OP_ALU) ? e_c : e_imm12);
        e_addr = (e_a + e_imm17) & WORD_MASK;
        case (e_rd)
            5'd0:    e_cond = 1'b1;
            5'd1:    e_cond = flags_r[2];
            5'd2:    e_cond = !flags_r[2];
            5'd3:    e_cond = flags_r[1];
            5'd4:    e_cond = !flags_r[1];
            5'd5:    e_cond = flags_r[3];
            5'd6:    e_cond = !flags_r[3];
            default: e_cond = 1'b0;
        endcase
        e_result  = 32'd0;
        e_wen     = 1'b0;
        e_load    = 1'b0;
        e_store   = 1'b0;
        e_flag_we = 1'b0;
        e_taken   = 1'b0;
        e_target  = de_pc_r + 32'd4 + {e_imm22[29:0], 2'b00};
        if (de_valid_r) begin
            case (e_op)
                OP_ALU, OP_ALUI: begin
                    e_result  = e_aluv[31:0];
                    e_wen     = 1'b1;
                    e_flag_we = 1'b1;
                end
                OP_LUI: begin
                    e_result = {de_ins_r[21:0], 10'd0};
                    e_wen    = 1'b1;
                end
                OP_LD: begin
                    e_wen  = 1'b1;
                    e_load = 1'b1;
                end
                OP_ST:   e_store = 1'b1;
                OP_BR:   e_taken = e_cond;
                OP_JALR: begin
                    e_result = de_pc_r + 32'd4;
                    e_wen    = 1'b1;
                    e_taken  = 1'b1;
                    e_target = e_a & WORD_MASK;
                end
                default: e_wen = 1'b0;
            endcase
        end else begin
            e_wen = 1'b0;
        end
    end

    // Front end: PC, halt latch, F/D and D/E registers with flush and stall.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_r        <= 32'd0;
            halted_r    <= 1'b0;
            fd_valid_r  <= 1'b0;
            fd_ins_r    <= 32'd0;
            fd_pc_r     <= 32'd0;
            de_valid_r  <= 1'b0;
            de_ins_r    <= 32'd0;
            de_pc_r     <= 32'd0;
            de_ra_val_r <= 32'd0;
            de_rb_val_r <= 32'd0;
            de_rc_val_r <= 32'd0;
        end else if (e_taken) begin
            // A taken transfer also cancels a HALT fetched on the wrong path.
            pc_r       <= e_target;
            halted_r   <= 1'b0;
            fd_valid_r <= 1'b0;
            de_valid_r <= 1'b0;
        end else if (load_use) begin
            de_valid_r <= 1'b0;
        end else begin
            de_valid_r  <= fd_valid_r;
            de_ins_r    <= fd_ins_r;
            de_pc_r     <= fd_pc_r;
            de_ra_val_r <= d_ra_val;
            de_rb_val_r <= d_rb_val;
            de_rc_val_r <= d_rc_val;
            if (halted_r || fetch_halt) begin
                halted_r   <= 1'b1;
                fd_valid_r <= 1'b0;
            end else begin
                pc_r       <= pc_r + 32'd4;
                fd_valid_r <= 1'b1;
                fd_ins_r   <= mem.mem_read0_data;
                fd_pc_r    <= pc_r;
            end
        end
    end

    // Back end: E/M and M/W registers plus the flags register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            em_wen_r    <= 1'b0;
            em_load_r   <= 1'b0;
            em_we_r     <= 1'b0;
            em_rd_r     <= 5'd0;
            em_result_r <= 32'd0;
            em_addr_r   <= 32'd0;
            em_wdata_r  <= 32'd0;
            mw_wen_r    <= 1'b0;
            mw_rd_r     <= 5'd0;
            mw_data_r   <= 32'd0;
            flags_r     <= 4'd0;
        end else begin
            em_wen_r    <= e_wen && (e_rd != 5'd0);
            em_load_r   <= e_load;
            em_we_r     <= e_store;
            em_rd_r     <= e_rd;
            em_result_r <= e_result;
            em_addr_r   <= e_addr;
            em_wdata_r  <= e_sd;
            mw_wen_r    <= em_wen_r;
            mw_rd_r     <= em_rd_r;
            mw_data_r   <= em_load_r ? mem.mem_read1_data : em_result_r;
            if (e_flag_we) begin
                flags_r <= e_aluv[35:32];
            end
        end
    end

    // Register file, written from W.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
        end else if (mw_wen_r) begin
            rf[mw_rd_r] <= mw_data_r;
        end
    end

    assign mem.mem_read0_addr = pc_r;
    assign mem.mem_read1_addr = em_addr_r;
    assign mem.mem_write_en   = em_we_r;
    assign mem.mem_write_addr = em_addr_r;
    assign mem.mem_write_data = em_wdata_r;
    assign ret_val = rf[1];
    assign flags   = flags_r;
    assign cpu_pc  = pc_r;
endmodule

// File: tb/tb_pipelined_cpu.sv
// Directed and randomized bench for pipelined_cpu; random programs are checked
// against an instruction-level interpreter of the ISA.
module tb_pipelined_cpu;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] ret_val, cpu_pc;
    logic [3:0]  flags;
    int          checks = 0;
    int          failures = 0;
    int          st_cnt = 0;
    logic [31:0] st_addr = 32'd0, st_data = 32'd0;

    logic [31:0] imem [256];
    logic [31:0] dmem [256];
    logic [31:0] mr   [32];
    logic [31:0] mdm  [256];
    logic [3:0]  mflags;
    logic [31:0] mhalt;
    int          mst;

    localparam logic [31:0] HALT = 32'hF800_0000;
    localparam logic [31:0] NOP  = 32'h3800_0000;

    pipelined_cpu_if mif();
    pipelined_cpu dut (.clk(clk), .reset(reset), .mem(mif), .ret_val(ret_val), .flags(flags), .cpu_pc(cpu_pc));

    always #5 clk = ~clk;

    assign mif.mem_read0_data = imem[8'(mif.mem_read0_addr >> 2)];
    assign mif.mem_read1_data = dmem[8'(mif.mem_read1_addr >> 2)];

    function automatic logic [31:0] f_alur(input logic [4:0] fn, input logic [4:0] ra, input logic [4:0] rb, input logic [4:0] rc);
        return {5'd0, ra, rb, fn, 7'd0, rc};
    endfunction
    function automatic logic [31:0] f_alui(input logic [4:0] fn, input logic [4:0] ra, input logic [4:0] rb, input logic [11:0] imm);
        return {5'd1, ra, rb, fn, imm};
    endfunction
    function automatic logic [31:0] f_mem(input logic [4:0] op, input logic [4:0] ra, input logic [4:0] rb, input logic [16:0] imm);
        return {op, ra, rb, imm};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: the store strobe seen before the edge is committed to dmem at the edge.
    task automatic tick();
        logic        we;
        logic [31:0] wa, wd;
        we = mif.mem_write_en;
        wa = mif.mem_write_addr;
        wd = mif.mem_write_data;
        @(posedge clk);
        if (we) begin
            dmem[8'(wa >> 2)] = wd;
            st_cnt++;
            st_addr = wa;
            st_data = wd;
        end
        #1;
    endtask

    task automatic fill_halt();
        reset = 1'b1;
        for (int i = 0; i < 256; i++) imem[i] = HALT;
    endtask

    task automatic start();
        reset = 1'b1;
        st_cnt = 0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    function automatic logic [31:0] m_alu(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b,
                                          output logic c, output logic o);
        longint unsigned ua, ub;
        longint          sa, sb, ss;
        logic signed [31:0] sv;
        logic [31:0]     r;
        ua = a; ub = b;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sv = a;
        ss = 0; c = 1'b0; o = 1'b0; r = 32'd0;
        case (f)
            5'd0: begin r = a + b; c = (ua + ub) > 64'd4294967295; ss = sa + sb; end
            5'd1: begin r = a - b; c = ua < ub; ss = sa - sb; end
            5'd2: r = a & b;
            5'd3: r = a | b;
            5'd4: r = a ^ b;
            5'd5: r = a << b[4:0];
            5'd6: r = a >> b[4:0];
            5'd7: r = sv >>> b[4:0];
            default: r = 32'd0;
        endcase
        if (f <= 5'd1) o = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
        return r;
    endfunction

    // Architectural interpreter: one instruction at a time, no pipeline notion.
    task automatic run_model();
        logic [31:0] pc, ins, nxt, a, b, r, addr;
        logic [4:0]  op, ra, rb;
        logic        c, o, z, s, cv, ov, take;
        for (int i = 0; i < 32; i++) mr[i] = 32'd0;
        c = 1'b0; z = 1'b0; s = 1'b0; o = 1'b0;
        mst = 0;
        pc = 32'd0;
        mhalt = 32'hDEAD_BEEF;
        for (int step = 0; step < 2000; step++) begin
            ins = imem[8'(pc >> 2)];
            op = ins[31:27]; ra = ins[26:22]; rb = ins[21:17];
            if (op == 5'd31) begin
                mhalt = pc;
                break;
            end
            nxt = pc + 32'd4;
            a = mr[rb];
            addr = a + {{15{ins[16]}}, ins[16:0]};
            case (op)
                5'd0, 5'd1: begin
                    b = (op == 5'd0) ? mr[ins[4:0]] : {{20{ins[11]}}, ins[11:0]};
                    r = m_alu(ins[16:12], a, b, cv, ov);
                    mr[ra] = r;
                    c = cv; o = ov; z = (r == 32'd0); s = r[31];
                end
                5'd2: mr[ra] = {ins[21:0], 10'd0};
                5'd3: mr[ra] = mdm[8'(addr >> 2)];
                5'd4: begin mdm[8'(addr >> 2)] = mr[ra]; mst++; end
                5'd5: begin
                    case (ra)
                        5'd0: take = 1'b1;
                        5'd1: take = z;
                        5'd2: take = !z;
                        5'd3: take = s;
                        5'd4: take = !s;
                        5'd5: take = c;
                        5'd6: take = !c;
                        default: take = 1'b0;
                    endcase
                    if (take) nxt = pc + 32'd4 + ({{10{ins[21]}}, ins[21:0]} * 32'd4);
                end
                5'd6: begin mr[ra] = pc + 32'd4; nxt = a & 32'hFFFF_FFFC; end
                default: nxt = pc + 32'd4;
            endcase
            mr[0] = 32'd0;
            pc = nxt;
        end
        mflags = {c, z, s, o};
    endtask

    initial begin
        // Two dependent immediates, reset state first.
        fill_halt();
        for (int i = 0; i < 256; i++) dmem[i] = 32'd0;
        imem[0] = f_alui(5'd0, 5'd1, 5'd0, 12'd5);
        imem[1] = f_alui(5'd0, 5'd1, 5'd1, 12'd7);
        tick(); tick();
        check("rst_ret_val", ret_val, 32'd0);
        check("rst_flags", flags, 32'd0);
        check("rst_cpu_pc", cpu_pc, 32'd0);
        check("rst_write_en", mif.mem_write_en, 32'd0);
        reset = 1'b0;
        repeat (5) tick();
        check("seq_r1_edge5", ret_val, 32'd5);
        tick();
        check("seq_r1_edge6_no_stall", ret_val, 32'd12);
        repeat (10) tick();
        check("seq_flags", flags, 32'd0);
        check("seq_halt_pc", cpu_pc, 32'h8);

        // Carry/zero from -1 + 1.
        fill_halt();
        imem[0] = f_alui(5'd0, 5'd2, 5'd0, 12'hFFF);
        imem[1] = f_alui(5'd0, 5'd1, 5'd2, 12'd1);
        start();
        repeat (15) tick();
        check("carry_r1", ret_val, 32'd0);
        check("carry_flags", flags, 32'b1100);

        // Store, load, load-use consumer.
        fill_halt();
        imem[0] = {5'd2, 5'd1, 22'd4};
        imem[1] = f_alui(5'd0, 5'd1, 5'd1, 12'h234);
        imem[2] = f_mem(5'd4, 5'd1, 5'd0, 17'h100);
        imem[3] = f_mem(5'd3, 5'd3, 5'd0, 17'h100);
        imem[4] = f_alur(5'd0, 5'd1, 5'd3, 5'd3);
        start();
        repeat (9) tick();
        check("ldst_r1_before_stall", ret_val, 32'h1234);
        tick();
        check("ldst_r1_after_stall", ret_val, 32'h2468);
        repeat (10) tick();
        check("ldst_store_count", st_cnt, 32'd1);
        check("ldst_store_addr", st_addr, 32'h100);
        check("ldst_store_data", st_data, 32'h1234);
        check("ldst_halt_pc", cpu_pc, 32'h14);

        // Taken branch over two increments.
        fill_halt();
        imem[0] = f_alui(5'd0, 5'd1, 5'd0, 12'd3);
        imem[1] = {5'd5, 5'd0, 22'd2};
        imem[2] = f_alui(5'd0, 5'd1, 5'd1, 12'd1);
        imem[3] = f_alui(5'd0, 5'd1, 5'd1, 12'd1);
        start();
        repeat (4) tick();
        check("br_fetch_target", cpu_pc, 32'h10);
        repeat (10) tick();
        check("br_r1", ret_val, 32'd3);
        check("br_halt_pc", cpu_pc, 32'h10);

        // JALR at 0x10 through r2 = 0x40.
        fill_halt();
        for (int i = 1; i < 16; i++) imem[i] = NOP;
        imem[0] = f_alui(5'd0, 5'd2, 5'd0, 12'h40);
        imem[4] = {5'd6, 5'd1, 5'd2, 17'd0};
        imem[5] = f_alui(5'd0, 5'd1, 5'd1, 12'd100);
        imem[6] = f_alui(5'd0, 5'd1, 5'd1, 12'd100);
        start();
        repeat (7) tick();
        check("jalr_fetch_target", cpu_pc, 32'h40);
        repeat (10) tick();
        check("jalr_link", ret_val, 32'h14);
        check("jalr_halt_pc", cpu_pc, 32'h40);

        // Reset mid-program, then restart from 0 and hold at HALT.
        fill_halt();
        imem[0] = {5'd2, 5'd1, 22'd4};
        imem[1] = f_alui(5'd0, 5'd1, 5'd1, 12'h234);
        imem[2] = f_mem(5'd4, 5'd1, 5'd0, 17'h100);
        imem[3] = f_mem(5'd3, 5'd3, 5'd0, 17'h100);
        imem[4] = f_alur(5'd0, 5'd1, 5'd3, 5'd3);
        start();
        repeat (7) tick();
        #2 reset = 1'b1;
        #1;
        check("midrst_ret_val", ret_val, 32'd0);
        check("midrst_cpu_pc", cpu_pc, 32'd0);
        check("midrst_flags", flags, 32'd0);
        check("midrst_write_en", mif.mem_write_en, 32'd0);
        tick();
        reset = 1'b0;
        check("restart_first_fetch", cpu_pc, 32'd0);
        tick();
        check("restart_second_fetch", cpu_pc, 32'd4);
        repeat (20) tick();
        check("restart_r1", ret_val, 32'h2468);
        check("restart_halt_pc", cpu_pc, 32'h14);
        repeat (5) tick();
        check("halt_holds_pc", cpu_pc, 32'h14);

        // Random programs against the interpreter.
        for (int it = 0; it < 10; it++) begin
            int n;
            int mism;
            logic [4:0] ra, rb, rc, fn;
            fill_halt();
            n = 0;
            for (int i = 0; i < 24; i++) begin
                ra = 5'($urandom_range(0, 7));
                rb = 5'($urandom_range(0, 7));
                rc = 5'($urandom_range(0, 7));
                fn = 5'($urandom_range(0, 9));
                case ($urandom_range(0, 9))
                    0, 1, 2: imem[n] = f_alur(fn, ra, rb, rc);
                    3, 4:    imem[n] = f_alui(fn, ra, rb, 12'($urandom));
                    5:       imem[n] = {5'd2, ra, 22'($urandom)};
                    6:       imem[n] = f_mem(5'd3, ra, rb, 17'($urandom));
                    7:       imem[n] = f_mem(5'd4, ra, rb, 17'($urandom));
                    8:       imem[n] = {5'd5, 5'($urandom_range(0, 8)), 22'($urandom_range(0, 3))};
                    default: imem[n] = {5'($urandom_range(7, 30)), 27'($urandom)};
                endcase
                n++;
            end
            for (int r = 1; r < 8; r++) begin
                imem[n] = f_mem(5'd4, 5'(r), 5'd0, 17'(32'h200 + 32'(r) * 32'd4));
                n++;
            end
            for (int i = 0; i < 256; i++) begin
                dmem[i] = $urandom;
                mdm[i] = dmem[i];
            end
            run_model();
            start();
            repeat (200) tick();
            check($sformatf("rand%0d_r1", it), ret_val, mr[1]);
            check($sformatf("rand%0d_flags", it), flags, mflags);
            check($sformatf("rand%0d_halt_pc", it), cpu_pc, mhalt);
            check($sformatf("rand%0d_store_count", it), st_cnt, mst);
            mism = 0;
            for (int i = 0; i < 256; i++) if (dmem[i] !== mdm[i]) mism++;
            check($sformatf("rand%0d_dmem_mismatches", it), mism, 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
